// File: rtl/systolic_feeder_pkg.sv
// Shared definitions for the systolic feeder and the array top that consumes its streams.
package systolic_feeder_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_N     = 4;
    localparam int LEN_W         = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        FLUSH = 2'd2
    } feeder_state_e;

endpackage

// File: rtl/systolic_feeder_if.sv
// Job control, operand input handshake and skewed output streams of the feeder.
interface systolic_feeder_if
    import systolic_feeder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int N     = DEFAULT_N
);
    logic               start;
    logic [LEN_W-1:0]   len;
    logic               in_valid;
    logic               in_ready;
    logic [N*WIDTH-1:0] in_a;
    logic [N*WIDTH-1:0] in_b;
    logic [N*WIDTH-1:0] out_a;
    logic [N*WIDTH-1:0] out_b;
    logic [N-1:0]       out_valid;
    logic               acc_clr;
    logic               busy;
    logic               done;

    modport master (
        output start, len, in_valid, in_a, in_b,
        input  in_ready, out_a, out_b, out_valid, acc_clr, busy, done
    );

    modport slave (
        input  start, len, in_valid, in_a, in_b,
        output in_ready, out_a, out_b, out_valid, acc_clr, busy, done
    );
endinterface

// File: rtl/systolic_feeder_skew_line.sv
// DEPTH-stage data/valid delay line; data is forced to zero in any stage without a valid beat.
module skew_line #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid
);
    logic [DEPTH:1]   vld_pipe;
    logic [WIDTH-1:0] dat_pipe [1:DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            for (int s = 1; s <= DEPTH; s++) dat_pipe[s] <= '0;
        end else begin
            vld_pipe[1] <= in_valid;
            dat_pipe[1] <= in_valid ? in_data : '0;
            for (int s = 2; s <= DEPTH; s++) begin
                vld_pipe[s] <= vld_pipe[s-1];
                dat_pipe[s] <= dat_pipe[s-1];
            end
        end
    end

    assign out_data  = dat_pipe[DEPTH];
    assign out_valid = vld_pipe[DEPTH];
endmodule

// File: rtl/systolic_feeder.sv
// Feeds K operand beats into an N-lane systolic array, skewing lane i by i+1 cycles.
module systolic_feeder
    import systolic_feeder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int N     = DEFAULT_N
) (
    input  logic              clk,
    input  logic              rst,
    systolic_feeder_if.slave  bus
);
    localparam int FW = (N > 1) ? $clog2(N) : 1;

    feeder_state_e    state;
    logic [LEN_W-1:0] cnt;
    logic [FW-1:0]    fcnt;
    logic             acc_clr_q;
    logic             done_q;
    logic             accept;

    assign accept       = (state == FEED) && bus.in_valid;
    assign bus.in_ready = (state == FEED);
    assign bus.busy     = (state != IDLE);
    assign bus.acc_clr  = acc_clr_q;
    assign bus.done     = done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            fcnt      <= '0;
            acc_clr_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            acc_clr_q <= 1'b0;
            done_q    <= 1'b0;
            case (state)
                IDLE: begin
                    // A start coinciding with a done pulse belongs to the finished job.
                    if (bus.start && !done_q) begin
                        if (bus.len == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state     <= FEED;
                            cnt       <= bus.len;
                            acc_clr_q <= 1'b1;
                        end
                    end
                end
                FEED: begin
                    if (accept) begin
                        cnt <= cnt - LEN_W'(1);
                        if (cnt == LEN_W'(1)) begin
                            state  <= FLUSH;
                            fcnt   <= FW'(N - 1);
                            done_q <= (N == 1);
                        end
                    end
                end
                FLUSH: begin
                    // done lines up with the last lane emitting the final beat.
                    if (fcnt == '0) begin
                        state <= IDLE;
                    end else begin
                        fcnt   <= fcnt - FW'(1);
                        done_q <= (fcnt == FW'(1));
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [WIDTH-1:0] a_d, b_d;
        logic             a_v, b_v;

        skew_line #(.WIDTH(WIDTH), .DEPTH(i + 1)) u_skew_a (
            .clk      (clk),
            .rst      (rst),
            .in_data  (bus.in_a[i*WIDTH +: WIDTH]),
            .in_valid (accept),
            .out_data (a_d),
            .out_valid(a_v)
        );

        skew_line #(.WIDTH(WIDTH), .DEPTH(i + 1)) u_skew_b (
            .clk      (clk),
            .rst      (rst),
            .in_data  (bus.in_b[i*WIDTH +: WIDTH]),
            .in_valid (accept),
            .out_data (b_d),
            .out_valid(b_v)
        );

        assign bus.out_a[i*WIDTH +: WIDTH] = a_d;
        assign bus.out_b[i*WIDTH +: WIDTH] = b_d;
        assign bus.out_valid[i]            = a_v & b_v;
    end
endmodule

// File: doc/systolic_feeder.md
SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 The parameters SHALL be: WIDTH, default 8, operand width per lane; N, default 4, number of array lanes (rows and columns).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 start  input  1  begin a feed job; sampled only in IDLE.
REQ-005 len  input  8  beats (K) in the job; latched on an accepted start.
REQ-006 in_valid  input  1  an operand beat is present on in_a/in_b.
REQ-007 in_ready  output  1  the feeder accepts the beat this cycle.
REQ-008 in_a  input  N*WIDTH  A-column beat; lane i is bits [i*WIDTH +: WIDTH].
REQ-009 in_b  input  N*WIDTH  B-row beat; same packing as in_a.
REQ-010 out_a  output  N*WIDTH  skewed A stream to the array's M inputs.
REQ-011 out_b  output  N*WIDTH  skewed B stream to the array's N inputs.
REQ-012 out_valid  output  N  per-lane valid accompanying out_a/out_b.
REQ-013 acc_clr  output  1  one-cycle clear pulse for the cell accumulators.
REQ-014 busy  output  1  high in FEED or FLUSH.
REQ-015 done  output  1  one-cycle pulse at job end.

Function
REQ-016 The FSM SHALL have three states: IDLE, FEED and FLUSH.
REQ-017 IDLE SHALL go to FEED when start=1 and len!=0, latch len into the beat counter and assert acc_clr for exactly the next cycle.
REQ-018 If start=1 and len=0 in IDLE, the block SHALL pulse done in the next cycle, SHALL NOT pulse acc_clr, and SHALL remain in IDLE.
REQ-019 in_ready SHALL equal 1 only in FEED; a beat is accepted when in_valid and in_ready are both 1.
REQ-020 Each accepted beat SHALL decrement the beat counter; the final accept SHALL move the FSM to FLUSH.
REQ-021 Lane i SHALL present an accepted beat's lane-i data on out_a/out_b with out_valid[i]=1 exactly i+1 cycles after the accept cycle.
REQ-022 Any FEED cycle without an accept SHALL inject a bubble: data 0 and valid 0 on every lane, skewed identically.
REQ-023 All skew stages SHALL carry zero data with valid 0 whenever no beat occupies them; out_a and out_b SHALL be 0 wherever out_valid is 0.
REQ-024 FLUSH SHALL last N cycles. done SHALL pulse during the cycle in which lane N-1 presents the final beat, which is N cycles after the last accept. The FSM SHALL then be in IDLE.
REQ-025 start SHALL be ignored while busy=1.
REQ-026 A start in the same cycle as done SHALL be ignored; a new job requires start while in IDLE.
REQ-027 Data SHALL pass unmodified; the feeder performs no arithmetic beyond counter decrement.

Reset
REQ-028 rst=1 SHALL immediately force IDLE, clear the counter and all skew stages, and drive all outputs to 0: out_a, out_b, out_valid, acc_clr, busy, done and in_ready.
REQ-029 Reset during FEED or FLUSH SHALL abort the job with no done pulse; no stale beat SHALL emerge after reset is released.

Structure
REQ-030 A shared package SHALL hold the FSM state enum and the default WIDTH and N constants, shared with the systolic array top.
REQ-031 One sub-module, skew_line (a parameterised DEPTH-stage register line carrying data and valid, clearable by rst), SHALL be instantiated once per lane per operand with DEPTH=i+1.

Verification
REQ-032 Basic job: N=4, len=3, three back-to-back beats with lane values 1..4 → lane i shows beats on cycles t+1+i; acc_clr pulses once; done is high at t+4 after the last accept.
REQ-033 Bubble: len=2 with in_valid low for one cycle between the beats → every lane shows valid,0,valid with the gap aligned per skew; done is delayed by one cycle.
REQ-034 len=0: start → done pulses next cycle; acc_clr, out_valid and busy stay 0.
REQ-035 Reset mid-FEED: assert rst after the 2nd of 5 beats → all outputs are 0 at once; after release no valid appears and there is no done.
REQ-036 Start while busy is ignored: a second start pulse during FLUSH → exactly one done, and len is not re-latched.
REQ-037 Width and packing: WIDTH=8, lane 3 value 0xFF → appears unchanged in out_a[31:24] four cycles after the accept.
